// File: rtl/mem_access_stage.sv
// MEM stage of the RV32I pipeline: data-memory handshake, store lane
// steering, load extension, and the MEM/WB pipeline register.
//
// state   | meaning
// --------+--------------------------------------------------------------
// ST_IDLE | no access outstanding; a request here may complete zero-wait
// ST_WAIT | request issued and not yet acknowledged; timeout counter runs
module mem_access_stage #(
   parameter int XLEN           = 32,
   parameter int TIMEOUT_CYCLES = 16
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            ex_valid,
   input  logic            ex_memRead,
   input  logic            ex_memWrite,
   input  logic            ex_regWrite,
   input  logic [4:0]      ex_rd,
   input  logic [2:0]      ex_f3,
   input  logic [XLEN-1:0] ex_alu_result,
   input  logic [XLEN-1:0] ex_store_data,
   output logic            mem_req,
   output logic            mem_we,
   output logic [XLEN-1:0] mem_addr,
   output logic [XLEN-1:0] mem_wdata,
   output logic [3:0]      mem_wstrb,
   input  logic [XLEN-1:0] mem_rdata,
   input  logic            mem_ready,
   output logic            stall_o,
   output logic            wb_valid,
   output logic            wb_regWrite,
   output logic            wb_memToReg,
   output logic [4:0]      wb_rd,
   output logic [XLEN-1:0] wb_alu_result,
   output logic [XLEN-1:0] wb_load_data,
   output logic            wb_misaligned,
   output logic            wb_bus_err
);

   typedef enum logic {ST_IDLE, ST_WAIT} state_t;

   localparam int            CW       = $clog2(TIMEOUT_CYCLES) + 1;
   localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYCLES - 1);

   state_t          state_q, state_d;
   logic [CW-1:0]   cnt_q, cnt_d;
   logic            mem_op;
   logic            legal;
   logic            fault;
   logic            timeout_hit;
   logic [1:0]      off;
   logic [7:0]      byte_sel;
   logic [15:0]     half_sel;
   logic [XLEN-1:0] load_ext;

   assign off    = ex_alu_result[1:0];
   assign mem_op = ex_valid & (ex_memRead | ex_memWrite);

   // Access legality: funct3 must name a real access of this direction and
   // the address must be naturally aligned for its size.
   always_comb begin
      legal = 1'b0;
      if (ex_memWrite) begin
         case (ex_f3)
            3'b000:  legal = 1'b1;
            3'b001:  legal = ~off[0];
            3'b010:  legal = (off == 2'b00);
            default: legal = 1'b0;
         endcase
      end else begin
         case (ex_f3)
            3'b000, 3'b100: legal = 1'b1;
            3'b001, 3'b101: legal = ~off[0];
            3'b010:         legal = (off == 2'b00);
            default:        legal = 1'b0;
         endcase
      end
   end

   assign fault = mem_op & ~legal;

   // Gated by rst_n so an in-flight request drops the moment reset asserts.
   assign mem_req     = mem_op & legal & rst_n;
   assign mem_we      = ex_memWrite;
   assign mem_addr    = {ex_alu_result[XLEN-1:2], 2'b00};
   assign timeout_hit = (state_q == ST_WAIT) & mem_req & ~mem_ready & (cnt_q == CNT_LAST);
   assign stall_o     = mem_req & ~mem_ready & ~timeout_hit;

   // Store lane steering: replicate the datum across all lanes, enable only
   // the addressed bytes.
   always_comb begin
      mem_wdata = '0;
      mem_wstrb = 4'b0000;
      if (ex_memWrite) begin
         case (ex_f3[1:0])
            2'b00: begin
               mem_wdata = {(XLEN/8){ex_store_data[7:0]}};
               mem_wstrb = 4'b0001 << off;
            end
            2'b01: begin
               mem_wdata = {(XLEN/16){ex_store_data[15:0]}};
               mem_wstrb = 4'b0011 << off;
            end
            2'b10: begin
               mem_wdata = ex_store_data;
               mem_wstrb = 4'b1111;
            end
            default: begin
               mem_wdata = '0;
               mem_wstrb = 4'b0000;
            end
         endcase
      end
   end

   assign byte_sel = mem_rdata[{off, 3'b000} +: 8];
   assign half_sel = mem_rdata[{off[1], 4'b0000} +: 16];

   // Load extraction and sign/zero extension.
   always_comb begin
      case (ex_f3)
         3'b000:  load_ext = {{(XLEN-8){byte_sel[7]}}, byte_sel};
         3'b100:  load_ext = {{(XLEN-8){1'b0}}, byte_sel};
         3'b001:  load_ext = {{(XLEN-16){half_sel[15]}}, half_sel};
         3'b101:  load_ext = {{(XLEN-16){1'b0}}, half_sel};
         default: load_ext = mem_rdata;
      endcase
   end

   // FSM state and wait counter registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   // Next state: enter WAIT on an unacknowledged request, leave on ready,
   // timeout, or a request that has vanished.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      case (state_q)
         ST_IDLE: begin
            cnt_d = '0;
            if (mem_req & ~mem_ready) begin
               state_d = ST_WAIT;
               cnt_d   = CW'(1);
            end
         end
         ST_WAIT: begin
            if (~mem_req | mem_ready | timeout_hit) begin
               state_d = ST_IDLE;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
         end
         default: begin
            state_d = ST_IDLE;
            cnt_d   = '0;
         end
      endcase
   end

   // MEM/WB register: bubble while stalled, otherwise commit the entry.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wb_valid      <= 1'b0;
         wb_regWrite   <= 1'b0;
         wb_memToReg   <= 1'b0;
         wb_rd         <= '0;
         wb_alu_result <= '0;
         wb_load_data  <= '0;
         wb_misaligned <= 1'b0;
         wb_bus_err    <= 1'b0;
      end else if (stall_o) begin
         wb_valid      <= 1'b0;
         wb_regWrite   <= 1'b0;
         wb_misaligned <= 1'b0;
         wb_bus_err    <= 1'b0;
      end else begin
         wb_valid      <= ex_valid;
         wb_regWrite   <= ex_regWrite & ex_valid & ~fault & ~timeout_hit;
         wb_memToReg   <= ex_memRead;
         wb_rd         <= ex_rd;
         wb_alu_result <= ex_alu_result;
         wb_load_data  <= load_ext;
         wb_misaligned <= fault;
         wb_bus_err    <= timeout_hit;
      end
   end

endmodule

// File: tb/tb_mem_access_stage.sv
// Bench for mem_access_stage: directed cases followed by random
// transactions checked against a behavioural model.
module tb_mem_access_stage;

   localparam int XLEN = 32;
   localparam int TO   = 16;

   logic            clk;
   logic            rst_n;
   logic            ex_valid, ex_memRead, ex_memWrite, ex_regWrite;
   logic [4:0]      ex_rd;
   logic [2:0]      ex_f3;
   logic [XLEN-1:0] ex_alu_result, ex_store_data;
   logic            mem_req, mem_we;
   logic [XLEN-1:0] mem_addr, mem_wdata;
   logic [3:0]      mem_wstrb;
   logic [XLEN-1:0] mem_rdata;
   logic            mem_ready;
   logic            stall_o;
   logic            wb_valid, wb_regWrite, wb_memToReg;
   logic [4:0]      wb_rd;
   logic [XLEN-1:0] wb_alu_result, wb_load_data;
   logic            wb_misaligned, wb_bus_err;

   int checks = 0;
   int passed = 0;

   mem_access_stage #(.XLEN(XLEN), .TIMEOUT_CYCLES(TO)) dut (
      .clk(clk), .rst_n(rst_n),
      .ex_valid(ex_valid), .ex_memRead(ex_memRead), .ex_memWrite(ex_memWrite),
      .ex_regWrite(ex_regWrite), .ex_rd(ex_rd), .ex_f3(ex_f3),
      .ex_alu_result(ex_alu_result), .ex_store_data(ex_store_data),
      .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
      .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb),
      .mem_rdata(mem_rdata), .mem_ready(mem_ready),
      .stall_o(stall_o),
      .wb_valid(wb_valid), .wb_regWrite(wb_regWrite), .wb_memToReg(wb_memToReg),
      .wb_rd(wb_rd), .wb_alu_result(wb_alu_result), .wb_load_data(wb_load_data),
      .wb_misaligned(wb_misaligned), .wb_bus_err(wb_bus_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) passed++;
      else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
   endtask

   // Access size in bytes from funct3.
   function automatic int size_of(input logic [2:0] f3);
      return 1 << f3[1:0];
   endfunction

   function automatic bit legal_m(input bit st, input logic [2:0] f3, input logic [31:0] addr);
      bit ok_f3;
      if (st) ok_f3 = (f3 == 3'd0) || (f3 == 3'd1) || (f3 == 3'd2);
      else    ok_f3 = (f3 == 3'd0) || (f3 == 3'd1) || (f3 == 3'd2) || (f3 == 3'd4) || (f3 == 3'd5);
      return ok_f3 && ((addr % size_of(f3)) == 0);
   endfunction

   function automatic logic [31:0] wdata_m(input logic [2:0] f3, input logic [31:0] d);
      logic [31:0] r;
      int n;
      n = size_of(f3);
      r = 0;
      for (int i = 0; i < 4; i++) r = r | (((d >> (8 * (i % n))) & 32'hFF) << (8 * i));
      return r;
   endfunction

   function automatic logic [3:0] wstrb_m(input logic [2:0] f3, input logic [31:0] addr);
      logic [3:0] s;
      int o;
      o = addr % 4;
      s = 4'b0000;
      for (int i = 0; i < 4; i++) if (i >= o && i < o + size_of(f3)) s[i] = 1'b1;
      return s;
   endfunction

   function automatic logic [31:0] load_m(input logic [2:0] f3, input logic [31:0] addr,
                                          input logic [31:0] rd_data);
      longint v;
      int n;
      n = size_of(f3);
      if (n == 4) return rd_data;
      v = (rd_data >> (8 * (addr % 4))) & ((64'd1 << (8 * n)) - 1);
      if (f3[2] == 1'b0 && v >= (64'd1 << (8 * n - 1))) v = v - (64'd1 << (8 * n));
      return v[31:0];
   endfunction

   // One EX/MEM entry held until it commits; lat = cycles mem_ready stays low.
   task automatic run_txn(input string name, input bit v, input bit rdm, input bit wrm,
                          input bit rw, input logic [4:0] rd, input logic [2:0] f3,
                          input logic [31:0] addr, input logic [31:0] data,
                          input logic [31:0] rdata, input int lat);
      bit mem_op, lg, fault, req, exp_to, exp_stall;
      mem_op = v && (rdm || wrm);
      lg     = legal_m(wrm, f3, addr);
      fault  = mem_op && !lg;
      req    = mem_op && lg;
      for (int k = 0; k <= TO + 2; k++) begin
         @(negedge clk);
         ex_valid = v; ex_memRead = rdm; ex_memWrite = wrm; ex_regWrite = rw;
         ex_rd = rd; ex_f3 = f3; ex_alu_result = addr; ex_store_data = data;
         if (req) mem_ready = (k >= lat);
         else     mem_ready = 1'($urandom_range(0, 1));
         mem_rdata = (req && k >= lat) ? rdata : 32'($urandom());
         #1;
         exp_to    = req && (k == TO - 1) && (k < lat);
         exp_stall = req && (k < lat) && !exp_to;
         chk({name, ":mem_req"}, 32'(mem_req), 32'(req));
         if (req) begin
            chk({name, ":mem_addr"}, mem_addr, addr & 32'hFFFF_FFFC);
            chk({name, ":mem_we"}, 32'(mem_we), 32'(wrm));
            chk({name, ":mem_wstrb"}, 32'(mem_wstrb), wrm ? 32'(wstrb_m(f3, addr)) : 32'd0);
            if (wrm) chk({name, ":mem_wdata"}, mem_wdata, wdata_m(f3, data));
         end
         chk({name, ":stall"}, 32'(stall_o), 32'(exp_stall));
         @(posedge clk);
         #1;
         if (exp_stall) begin
            chk({name, ":bubble_valid"}, 32'(wb_valid), 32'd0);
            chk({name, ":bubble_regwrite"}, 32'(wb_regWrite), 32'd0);
            chk({name, ":bubble_buserr"}, 32'(wb_bus_err), 32'd0);
         end else begin
            chk({name, ":wb_valid"}, 32'(wb_valid), 32'(v));
            chk({name, ":wb_regWrite"}, 32'(wb_regWrite), 32'(rw && v && !fault && !exp_to));
            chk({name, ":wb_memToReg"}, 32'(wb_memToReg), 32'(rdm));
            chk({name, ":wb_rd"}, 32'(wb_rd), 32'(rd));
            chk({name, ":wb_alu_result"}, wb_alu_result, addr);
            chk({name, ":wb_misaligned"}, 32'(wb_misaligned), 32'(fault));
            chk({name, ":wb_bus_err"}, 32'(wb_bus_err), 32'(exp_to));
            if (req && !wrm && !exp_to)
               chk({name, ":wb_load_data"}, wb_load_data, load_m(f3, addr, rdata));
            break;
         end
      end
   endtask

   initial begin
      logic [2:0]  f3;
      logic [31:0] a;
      int          kind, lat;
      bit          rdm, wrm;

      rst_n = 1'b0;
      ex_valid = 0; ex_memRead = 0; ex_memWrite = 0; ex_regWrite = 0;
      ex_rd = 0; ex_f3 = 0; ex_alu_result = 0; ex_store_data = 0;
      mem_rdata = 0; mem_ready = 0;
      #12;
      chk("reset:wb_valid", 32'(wb_valid), 32'd0);
      chk("reset:wb_regWrite", 32'(wb_regWrite), 32'd0);
      chk("reset:wb_alu_result", wb_alu_result, 32'd0);
      chk("reset:wb_flags", {30'd0, wb_misaligned, wb_bus_err}, 32'd0);
      chk("reset:mem_req", 32'(mem_req), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;

      run_txn("add",      1, 0, 0, 1, 5'd5, 3'd0, 32'h1234, 0, 0, 0);
      run_txn("lb",       1, 1, 0, 1, 5'd6, 3'd0, 32'h1003, 0, 32'h80FF_0000, 0);
      run_txn("lbu",      1, 1, 0, 1, 5'd6, 3'd4, 32'h1003, 0, 32'h80FF_0000, 0);
      run_txn("sh",       1, 0, 1, 0, 5'd0, 3'd1, 32'h102, 32'hDEAD_BEEF, 0, 0);
      run_txn("lw_wait",  1, 1, 0, 1, 5'd7, 3'd2, 32'h200, 0, 32'hCAFE_BABE, 3);
      run_txn("lw_mis",   1, 1, 0, 1, 5'd8, 3'd2, 32'h201, 0, 0, 0);
      run_txn("sb_f3bad", 1, 0, 1, 0, 5'd0, 3'd4, 32'h204, 32'h55, 0, 0);
      run_txn("timeout",  1, 1, 0, 1, 5'd9, 3'd2, 32'h400, 0, 32'h1111_2222, 100);
      run_txn("ready_at_last", 1, 1, 0, 1, 5'd10, 3'd5, 32'h402, 0, 32'h9876_5432, TO - 1);
      run_txn("rw_both",  1, 1, 1, 1, 5'd11, 3'd2, 32'h500, 32'hA5A5_5A5A, 0, 2);
      run_txn("invalid",  0, 1, 0, 1, 5'd12, 3'd2, 32'h600, 0, 0, 0);

      // Reset dropped while a load is waiting.
      @(negedge clk);
      ex_valid = 1; ex_memRead = 1; ex_memWrite = 0; ex_regWrite = 1;
      ex_rd = 5'd13; ex_f3 = 3'd2; ex_alu_result = 32'h300; mem_ready = 0;
      #1;
      chk("rstwait:stall_before", 32'(stall_o), 32'd1);
      @(negedge clk);
      @(negedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      chk("rstwait:mem_req", 32'(mem_req), 32'd0);
      chk("rstwait:stall", 32'(stall_o), 32'd0);
      chk("rstwait:wb_valid", 32'(wb_valid), 32'd0);
      ex_valid = 0;
      @(negedge clk);
      rst_n = 1'b1;
      run_txn("after_rst", 1, 0, 0, 1, 5'd14, 3'd0, 32'hABCD, 0, 0, 0);

      for (int n = 0; n < 40; n++) begin
         kind = $urandom_range(0, 9);
         rdm = (kind >= 2 && kind <= 5) || kind == 9;
         wrm = kind >= 6;
         if ($urandom_range(0, 3) != 0) begin
            if (wrm) f3 = 3'($urandom_range(0, 2));
            else begin
               f3 = 3'($urandom_range(0, 4));
               if (f3 == 3'd3) f3 = 3'd5;
            end
         end else f3 = 3'($urandom_range(0, 7));
         a = $urandom();
         if ($urandom_range(0, 1) == 1) a = a & 32'hFFFF_FFFC;
         lat = ($urandom_range(0, 9) == 0) ? 20 : $urandom_range(0, 3);
         run_txn("rand", ($urandom_range(0, 7) != 0), rdm, wrm, 1'($urandom_range(0, 1)),
                 5'($urandom()), f3, a, $urandom(), $urandom(), lat);
      end

      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule

// File: doc/mem_access_stage.md
Name: mem_access_stage

Overview:
- MEM stage of the 5-stage RV32I pipeline. Consumes the EX/MEM bundle: ALU result as address, forwarded store data, and the control bits memRead, memWrite and regWrite.
- Drives a single-port data-memory request/ready handshake, performs byte/half/word store lane steering and load sign/zero extension.
- Owns the MEM/WB pipeline register.
- Stalls the pipeline while a memory access is outstanding, and reports misaligned accesses and bus timeouts.

Parameters:
- XLEN, 32, datapath width.
- TIMEOUT_CYCLES, 16, cycles an access may wait for mem_ready before a bus error is flagged (>=2).

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- ex_valid  in  1  EX/MEM entry valid.
- ex_memRead  in  1  load.
- ex_memWrite  in  1  store.
- ex_regWrite  in  1  writes rd.
- ex_rd  in  5  destination register.
- ex_f3  in  3  funct3 (access size/sign).
- ex_alu_result  in  XLEN  address, or result for non-memory ops.
- ex_store_data  in  XLEN  store data, already forwarded.
- mem_req  out  1  access request.
- mem_we  out  1  1 = write.
- mem_addr  out  XLEN  word-aligned address ({addr[31:2],2'b00}).
- mem_wdata  out  XLEN  lane-replicated write data.
- mem_wstrb  out  4  byte enables.
- mem_rdata  in  XLEN  read data, valid when mem_ready.
- mem_ready  in  1  access complete this cycle.
- stall_o  out  1  hold IF..EX/MEM.
- wb_valid  out  1  MEM/WB valid.
- wb_regWrite  out  1  register write enable.
- wb_memToReg  out  1  select wb_load_data.
- wb_rd  out  5  destination register.
- wb_alu_result  out  XLEN  passthrough ALU result.
- wb_load_data  out  XLEN  extended load data.
- wb_misaligned  out  1  misaligned or illegal-f3 access.
- wb_bus_err  out  1  access timed out.

Behaviour:
- Reset (rst_n=0, async): all wb_* outputs 0, FSM=IDLE, timeout counter=0.
- Memory op: mem_op = ex_valid & (ex_memRead | ex_memWrite). If both memRead and memWrite are set, the access is a store.
- Legality:
  - Loads: f3 in {000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU}.
  - Stores: f3 in {000 SB, 001 SH, 010 SW}.
  - Half-word needs addr[0]=0. Word needs addr[1:0]=00.
  - Anything else is a fault: no mem_req, wb_misaligned=1, wb_regWrite=0, no stall, 1 cycle.
- mem_req is combinational: 1 when mem_op & legal, in either IDLE or WAIT. mem_addr/mem_we/mem_wdata/mem_wstrb derive combinationally from the ex_* inputs.
- Upstream holds ex_* stable while stall_o=1.
- Stores:
  - SB: wdata={4{d[7:0]}}, wstrb=0001<<addr[1:0].
  - SH: wdata={2{d[15:0]}}, wstrb=0011<<addr[1:0].
  - SW: wdata=d, wstrb=1111.
  - Loads drive wstrb=0000.
- Loads: select byte/half by addr[1:0] from mem_rdata. Sign-extend for LB/LH, zero-extend for LBU/LHU.
- stall_o = mem_req & ~mem_ready & ~timeout_hit. Zero-wait access (ready in the same cycle) completes with no stall.
- FSM:
  - IDLE -> WAIT when mem_req & ~mem_ready; counter=1.
  - WAIT: counter increments each cycle. On mem_ready -> IDLE, complete normally. When counter==TIMEOUT_CYCLES-1 and ~mem_ready: timeout_hit=1, stall_o=0 that cycle, -> IDLE, entry commits with wb_bus_err=1 and wb_regWrite=0.
  - mem_ready and timeout in the same cycle: ready wins, no error.
- MEM/WB register, each clk:
  - If stall_o: insert a bubble (wb_valid=0, wb_regWrite=0, flags 0). Other wb fields are don't-care but are held.
  - Else: wb_valid=ex_valid, wb_regWrite=ex_regWrite & ex_valid & ~fault, wb_memToReg=ex_memRead, and capture rd/alu_result/load_data/flags.
- Non-memory ops: 1-cycle passthrough, no mem_req.
- ex_valid=0: no request, wb_valid=0 next cycle.
- rd=0: passthrough unchanged; the register file ignores x0.
- Reset asserted mid-WAIT: immediately IDLE, mem_req drops (combinational on state/reset), wb cleared.

Test Plan:
- ADD passthrough: ex_valid=1, regWrite=1, rd=5, alu_result=0x1234 -> next cycle wb_valid=1, wb_rd=5, wb_alu_result=0x1234, mem_req never 1, stall_o=0.
- LB sign-extend, zero wait: addr=0x1003, mem_rdata=0x80FF_0000, mem_ready=1 same cycle -> stall_o=0, next cycle wb_load_data=0xFFFF_FF80. Repeat with LBU -> 0x0000_0080.
- SH at 0x102 with data=0xDEAD_BEEF -> mem_addr=0x100, wdata=0xBEEF_BEEF, wstrb=1100, mem_we=1.
- Wait states: LW addr=0x200, mem_ready low 3 cycles -> stall_o=1 for 3 cycles with wb_valid=0 bubbles, mem_req and mem_addr stable; ready with rdata=0xCAFEBABE -> next cycle wb_load_data=0xCAFEBABE, wb_regWrite=1.
- Misaligned LW addr=0x201 -> no mem_req, next cycle wb_misaligned=1, wb_regWrite=0, no stall.
- Timeout: mem_ready held 0 with TIMEOUT_CYCLES=16 -> stall_o high for cycles 1..15 only, then wb_bus_err=1, wb_regWrite=0. Separately, drop rst_n mid-WAIT -> mem_req=0 and wb_valid=0 immediately.
